// File: rtl/morty_mem_stage.sv
// Morty RV32 MEM stage: runs one Wishbone-classic data access per load/store,
// holds the pipeline while it is in flight, and aligns/extends load data.
module morty_mem_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] data_ALUo_i,
    input  logic [31:0] drs2_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [3:0]  exc_i,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_dat_o,
    output logic [3:0]  dbus_sel_o,
    output logic        dbus_we_o,
    output logic        dbus_cyc_o,
    output logic        dbus_stb_o,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack_i,
    input  logic        dbus_err_i,
    output logic        stall_mem_o,
    output logic [4:0]  rd_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] data_o,
    output logic [3:0]  exc_o
);
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;
    localparam logic [7:0] TIMEOUT_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, dat_q, rdata_q;
    logic [3:0]  sel_q, exc_q;
    logic        we_q, cyc_q, unsigned_q;
    logic [1:0]  size_q, off_q;
    logic [7:0]  cnt_q;

    logic        is_mem, aligned, start;
    logic [3:0]  sel_d;
    logic [31:0] dat_d;
    logic        timed_out, bus_end, bus_fault;
    logic [31:0] ld_shift, ld_data;

    assign rd_o  = rd_i;
    assign pc_o  = pc_i;
    assign pc4_o = pc4_i;

    assign dbus_addr_o = addr_q;
    assign dbus_dat_o  = dat_q;
    assign dbus_sel_o  = sel_q;
    assign dbus_we_o   = we_q;
    assign dbus_cyc_o  = cyc_q;
    assign dbus_stb_o  = cyc_q;

    assign is_mem = mem_rd_i | mem_wr_i;

    // Alignment check and store lane steering; size 2'b11 falls into the word case.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        aligned = 1'b1;
        sel_d   = 4'b1111;
        dat_d   = drs2_i;
        case (mem_size_i)
            2'b00: begin
                sel_d = 4'b0001 << data_ALUo_i[1:0];
                dat_d = {4{drs2_i[7:0]}};
            end
            2'b01: begin
                aligned = ~data_ALUo_i[0];
                sel_d   = data_ALUo_i[1] ? 4'b1100 : 4'b0011;
                dat_d   = {2{drs2_i[15:0]}};
            end
            default: aligned = (data_ALUo_i[1:0] == 2'b00);
        endcase
    end

    assign start = (state_q == IDLE) && is_mem && (exc_i == 4'd0) && aligned && !clear_i;

    assign timed_out = (cnt_q == TIMEOUT_LAST);
    assign bus_end   = dbus_ack_i | dbus_err_i | timed_out;
    assign bus_fault = dbus_err_i | (~dbus_ack_i & timed_out);

    assign ld_shift = rdata_q >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   ld_data = {{24{~unsigned_q & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = {{16{~unsigned_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stall_mem_o = 1'b0;
        data_o      = data_ALUo_i;
        exc_o       = 4'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = BUSY;
                    stall_mem_o = 1'b1;
                end
                if (!clear_i) begin
                    if (exc_i != 4'd0)
                        exc_o = exc_i;
                    else if (is_mem && !aligned)
                        exc_o = mem_wr_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                end
            end
            BUSY: begin
                stall_mem_o = 1'b1;
                // A flush that coincides with completion skips DRAIN entirely.
                if (bus_end)
                    state_d = clear_i ? IDLE : DONE;
                else if (clear_i)
                    state_d = DRAIN;
            end
            DONE: begin
                state_d = IDLE;
                if (!we_q)
                    data_o = ld_data;
                if (!clear_i)
                    exc_o = exc_q;
            end
            DRAIN: begin
                stall_mem_o = 1'b1;
                if (bus_end)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'd0;
            addr_q     <= 32'd0;
            dat_q      <= 32'd0;
            rdata_q    <= 32'd0;
            size_q     <= 2'd0;
            off_q      <= 2'd0;
            unsigned_q <= 1'b0;
            exc_q      <= 4'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cyc_q   <= (state_d == BUSY) || (state_d == DRAIN);
            if (start) begin
                addr_q     <= {data_ALUo_i[31:2], 2'b00};
                off_q      <= data_ALUo_i[1:0];
                sel_q      <= sel_d;
                dat_q      <= dat_d;
                we_q       <= mem_wr_i;
                size_q     <= mem_size_i;
                unsigned_q <= mem_unsigned_i;
                cnt_q      <= 8'd0;
            end else if (cyc_q) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == BUSY && bus_end) begin
                exc_q <= bus_fault ? (we_q ? EXC_ST_FAULT : EXC_LD_FAULT) : 4'd0;
                if (dbus_ack_i && !dbus_err_i)
                    rdata_q <= dbus_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_morty_mem_stage.sv
// Self-checking bench for morty_mem_stage: directed scenarios plus random
// loads/stores checked against a byte-addressed memory model.
module tb_morty_mem_stage;
    logic        clk = 1'b0;
    logic        rst, clear_i;
    logic [4:0]  rd_i;
    logic [31:0] pc_i, pc4_i, data_ALUo_i, drs2_i;
    logic        mem_rd_i, mem_wr_i, mem_unsigned_i;
    logic [1:0]  mem_size_i;
    logic [3:0]  exc_i;
    logic [31:0] dbus_addr_o, dbus_dat_o, dbus_dat_i;
    logic [3:0]  dbus_sel_o;
    logic        dbus_we_o, dbus_cyc_o, dbus_stb_o, dbus_ack_i, dbus_err_i;
    logic        stall_mem_o;
    logic [4:0]  rd_o;
    logic [31:0] pc_o, pc4_o, data_o;
    logic [3:0]  exc_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] mem_model [int];

    typedef struct packed {
        int          stall;
        int          busy;
        logic [31:0] data;
        logic [3:0]  exc;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] adr;
        logic        we;
        logic        done;
    } res_t;

    morty_mem_stage #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .rd_i(rd_i), .pc_i(pc_i), .pc4_i(pc4_i),
        .data_ALUo_i(data_ALUo_i), .drs2_i(drs2_i),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .exc_i(exc_i),
        .dbus_addr_o(dbus_addr_o), .dbus_dat_o(dbus_dat_o), .dbus_sel_o(dbus_sel_o),
        .dbus_we_o(dbus_we_o), .dbus_cyc_o(dbus_cyc_o), .dbus_stb_o(dbus_stb_o),
        .dbus_dat_i(dbus_dat_i), .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i),
        .stall_mem_o(stall_mem_o),
        .rd_o(rd_o), .pc_o(pc_o), .pc4_o(pc4_o), .data_o(data_o), .exc_o(exc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Word read from the model; untouched words hold random contents.
    function automatic logic [31:0] mem_read(input int idx);
        if (!mem_model.exists(idx))
            mem_model[idx] = $urandom;
        return mem_model[idx];
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input int nbytes,
                                             input bit uns, input int off);
        longint v;
        v = longint'(word >> (8 * off));
        if (nbytes == 1) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (nbytes == 2) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    task automatic idle_cycle(input logic [31:0] alu);
        @(negedge clk);
        mem_rd_i    = 1'b0;
        mem_wr_i    = 1'b0;
        clear_i     = 1'b0;
        exc_i       = 4'd0;
        data_ALUo_i = alu;
        #1;
    endtask

    // Issues one load/store and plays the slave: ack/err after `waits` BUSY
    // cycles (resp 0=ack, 1=err, 2=silent). Returns what was seen on the bus
    // and the first non-stalled cycle's data/exception.
    task automatic mem_op(input bit wr, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input int resp, input logic [31:0] rword,
                          output res_t r);
        r = '0;
        @(negedge clk);
        mem_rd_i       = !wr;
        mem_wr_i       = wr;
        mem_size_i     = size;
        mem_unsigned_i = uns;
        data_ALUo_i    = addr;
        drs2_i         = wdata;
        exc_i          = 4'd0;
        clear_i        = 1'b0;
        #1;
        for (int i = 0; i < 300; i++) begin
            if (!stall_mem_o) begin
                r.data = data_o;
                r.exc  = exc_o;
                r.done = 1'b1;
                break;
            end
            r.stall++;
            if (dbus_cyc_o) begin
                r.busy++;
                r.sel = dbus_sel_o;
                r.dat = dbus_dat_o;
                r.adr = dbus_addr_o;
                r.we  = dbus_we_o;
                if (r.busy > waits) begin
                    if (resp == 0) begin
                        dbus_ack_i = 1'b1;
                        dbus_dat_i = rword;
                    end else if (resp == 1) begin
                        dbus_err_i = 1'b1;
                    end
                end
            end
            @(negedge clk);
            dbus_ack_i = 1'b0;
            dbus_err_i = 1'b0;
            dbus_dat_i = $urandom;
            #1;
        end
        check("op_completes", 32'(r.done), 32'd1);
    endtask

    initial begin
        res_t r;
        rst = 1'b1; clear_i = 1'b0; rd_i = 5'd0; pc_i = 32'd0; pc4_i = 32'd0;
        data_ALUo_i = 32'd0; drs2_i = 32'd0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
        mem_size_i = 2'b10; mem_unsigned_i = 1'b0; exc_i = 4'd0;
        dbus_dat_i = 32'd0; dbus_ack_i = 1'b0; dbus_err_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_cyc", 32'(dbus_cyc_o), 32'd0);
        check("rst_stb", 32'(dbus_stb_o), 32'd0);
        check("rst_we", 32'(dbus_we_o), 32'd0);
        check("rst_sel", 32'(dbus_sel_o), 32'd0);
        check("rst_addr", dbus_addr_o, 32'd0);
        check("rst_dat", dbus_dat_o, 32'd0);
        check("rst_stall", 32'(stall_mem_o), 32'd0);
        rst = 1'b0;

        // LW 0x100, two wait states
        mem_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 2, 0, 32'hDEADBEEF, r);
        check("lw_stall", 32'(r.stall), 32'd4);
        check("lw_adr", r.adr, 32'h100);
        check("lw_we", 32'(r.we), 32'd0);
        check("lw_data", r.data, 32'hDEADBEEF);
        check("lw_exc", 32'(r.exc), 32'd0);
        idle_cycle(32'h0000_1111);
        check("after_done_stall", 32'(stall_mem_o), 32'd0);
        check("after_done_data", data_o, 32'h0000_1111);
        check("after_done_cyc", 32'(dbus_cyc_o), 32'd0);

        // LB / LBU at 0x103
        mem_op(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 0, 0, 32'h80FF_1234, r);
        check("lb_stall", 32'(r.stall), 32'd2);
        check("lb_data", r.data, 32'hFFFF_FF80);
        mem_op(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 1, 0, 32'h80FF_1234, r);
        check("lbu_data", r.data, 32'h0000_0080);

        // SH 0xABCD at 0x202
        mem_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 0, 0, 32'd0, r);
        check("sh_sel", 32'(r.sel), 32'hC);
        check("sh_dat", r.dat, 32'hABCD_ABCD);
        check("sh_we", 32'(r.we), 32'd1);
        check("sh_adr", r.adr, 32'h200);
        check("sh_exc", 32'(r.exc), 32'd0);

        // Misaligned word load and store
        mem_op(1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 0, 0, 32'd0, r);
        check("lw_mis_exc", 32'(r.exc), 32'd4);
        check("lw_mis_stall", 32'(r.stall), 32'd0);
        idle_cycle(32'd0);
        check("lw_mis_cyc", 32'(dbus_cyc_o), 32'd0);
        mem_op(1'b1, 2'b10, 1'b0, 32'h101, 32'h1234, 0, 0, 32'd0, r);
        check("sw_mis_exc", 32'(r.exc), 32'd6);
        idle_cycle(32'd0);
        check("sw_mis_cyc", 32'(dbus_cyc_o), 32'd0);

        // Upstream exception outranks misalignment; pass-through fields
        @(negedge clk);
        mem_rd_i = 1'b1; mem_size_i = 2'b10; data_ALUo_i = 32'h101; exc_i = 4'd2;
        rd_i = 5'h1A; pc_i = 32'h8000_0040; pc4_i = 32'h8000_0044;
        #1;
        check("exc_in_prio", 32'(exc_o), 32'd2);
        check("exc_in_stall", 32'(stall_mem_o), 32'd0);
        check("pass_rd", 32'(rd_o), 32'h1A);
        check("pass_pc", pc_o, 32'h8000_0040);
        check("pass_pc4", pc4_o, 32'h8000_0044);
        idle_cycle(32'd0);
        check("exc_in_nocyc", 32'(dbus_cyc_o), 32'd0);

        // clear_i in IDLE suppresses everything
        @(negedge clk);
        mem_rd_i = 1'b1; data_ALUo_i = 32'h600; exc_i = 4'd3; clear_i = 1'b1;
        #1;
        check("clr_idle_exc", 32'(exc_o), 32'd0);
        check("clr_idle_stall", 32'(stall_mem_o), 32'd0);
        idle_cycle(32'd0);
        check("clr_idle_nocyc", 32'(dbus_cyc_o), 32'd0);

        // Bus error on a store, timeout on a load
        mem_op(1'b1, 2'b10, 1'b0, 32'h400, 32'h5555_AAAA, 0, 1, 32'd0, r);
        check("sw_err_exc", 32'(r.exc), 32'd7);
        check("sw_err_stall", 32'(r.stall), 32'd2);
        mem_op(1'b0, 2'b10, 1'b0, 32'h404, 32'd0, 0, 2, 32'd0, r);
        check("lw_to_exc", 32'(r.exc), 32'd5);
        check("lw_to_busy", 32'(r.busy), 32'd64);

        // clear_i during BUSY: drain until ack, no DONE cycle
        @(negedge clk);
        mem_rd_i = 1'b1; mem_size_i = 2'b10; data_ALUo_i = 32'h300; exc_i = 4'd0;
        #1;
        check("drain_start_stall", 32'(stall_mem_o), 32'd1);
        @(negedge clk); #1;
        check("drain_busy_cyc", 32'(dbus_cyc_o), 32'd1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0; mem_rd_i = 1'b0;
        #1;
        check("drain_cyc", 32'(dbus_cyc_o), 32'd1);
        check("drain_stall", 32'(stall_mem_o), 32'd1);
        @(negedge clk);
        dbus_ack_i = 1'b1; dbus_dat_i = 32'h1234_5678;
        #1;
        check("drain_ack_stall", 32'(stall_mem_o), 32'd1);
        @(negedge clk);
        dbus_ack_i = 1'b0; data_ALUo_i = 32'h55;
        #1;
        check("drain_end_stall", 32'(stall_mem_o), 32'd0);
        check("drain_end_cyc", 32'(dbus_cyc_o), 32'd0);
        check("drain_end_exc", 32'(exc_o), 32'd0);
        check("drain_no_done", data_o, 32'h55);

        // Reset mid-access drops the cycle
        @(negedge clk);
        mem_rd_i = 1'b1; data_ALUo_i = 32'h500;
        @(negedge clk); #1;
        check("rst_mid_busy", 32'(dbus_cyc_o), 32'd1);
        rst = 1'b1; mem_rd_i = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_cyc", 32'(dbus_cyc_o), 32'd0);
        check("rst_mid_stb", 32'(dbus_stb_o), 32'd0);
        rst = 1'b0;

        // Random loads/stores against the memory model
        for (int k = 0; k < 40; k++) begin
            bit          wr, uns, al;
            logic [1:0]  sz;
            int          off, idx, waits, nb;
            logic [31:0] a, wd, word, tmp;
            wr    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            sz    = 2'($urandom_range(0, 3));
            off   = int'($urandom_range(0, 3));
            idx   = int'($urandom_range(0, 15)) + 32'h400;
            waits = int'($urandom_range(0, 3));
            wd    = $urandom;
            a     = 32'(idx * 4 + off);
            nb    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            al    = (off % nb) == 0;
            word  = mem_read(idx);
            mem_op(wr, sz, uns, a, wd, waits, 0, word, r);
            if (!al) begin
                check("rnd_mis_stall", 32'(r.stall), 32'd0);
                check("rnd_mis_exc", 32'(r.exc), wr ? 32'd6 : 32'd4);
                check("rnd_mis_data", r.data, a);
            end else begin
                check("rnd_stall", 32'(r.stall), 32'(waits + 2));
                check("rnd_adr", r.adr, 32'(idx * 4));
                check("rnd_we", 32'(r.we), 32'(wr));
                check("rnd_exc", 32'(r.exc), 32'd0);
                if (wr) begin
                    if (nb == 1) begin
                        check("rnd_sb_sel", 32'(r.sel), 32'(1 << off));
                        check("rnd_sb_dat", r.dat, 32'(wd % 256) * 32'h0101_0101);
                    end else if (nb == 2) begin
                        check("rnd_sh_sel", 32'(r.sel), (off >= 2) ? 32'hC : 32'h3);
                        check("rnd_sh_dat", r.dat, 32'(wd % 65536) * 32'h0001_0001);
                    end else begin
                        check("rnd_sw_sel", 32'(r.sel), 32'hF);
                        check("rnd_sw_dat", r.dat, wd);
                    end
                    check("rnd_st_data", r.data, a);
                    tmp = mem_model[idx];
                    for (int b = 0; b < nb; b++)
                        tmp[8 * (off + b) +: 8] = wd[8 * b +: 8];
                    mem_model[idx] = tmp;
                end else begin
                    check("rnd_ld_data", r.data, exp_load(word, nb, uns, off));
                end
            end
        end

        idle_cycle(32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
